// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding controller.
//  reg_idx_t   architectural register index (x0..x31)
//  REG_ZERO    hardwired-zero register, never forwarded
//  fwd_sel_e   EX operand select: 00 register file, 01 WB result, 10 MEM ALU result
package hazard_pkg;

    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_e;

    // MEM is the younger producer, so it is checked first.
    function automatic fwd_sel_e fwd_select(
        input reg_idx_t rs,
        input reg_idx_t rd_m,
        input logic     we_m,
        input reg_idx_t rd_w,
        input logic     we_w
    );
        if (we_m && (rd_m != REG_ZERO) && (rd_m == rs)) begin
            return FWD_MEM;
        end else if (we_w && (rd_w != REG_ZERO) && (rd_w == rs)) begin
            return FWD_WB;
        end
        return FWD_NONE;
    endfunction

endpackage

// File: rtl/hazard_shadow_stage.sv
// One stage of the controller's private shadow pipe (destination register
// and write-enable of the instruction that occupied the previous stage).
// Ports:
//  clk         core clock
//  rst_n       asynchronous active-low reset, clears to a non-writer to x0
//  rd_i        destination register entering the stage
//  regwrite_i  write-enable entering the stage
//  rd_o        registered destination register
//  regwrite_o  registered write-enable
module hazard_shadow_stage
    import hazard_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  reg_idx_t rd_i,
    input  logic     regwrite_i,
    output reg_idx_t rd_o,
    output logic     regwrite_o
);

    reg_idx_t rd_q;
    logic     regwrite_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q       <= REG_ZERO;
            regwrite_q <= 1'b0;
        end else begin
            rd_q       <= rd_i;
            regwrite_q <= regwrite_i;
        end
    end

    assign rd_o       = rd_q;
    assign regwrite_o = regwrite_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard and forwarding controller for a 5-stage pipeline.
// Tracks MEM/WB writers in its own shadow pipe, resolves load-use stalls and
// taken-branch flushes combinationally, and counts both event types.
// Ports:
//  clk, rst_n          core clock, asynchronous active-low reset
//  Rs1D, Rs2D          Decode-stage source registers
//  RSD1_E, RSD2_E      Execute-stage source registers
//  RdE, RegWriteE      Execute-stage destination and write-enable
//  IsLoadE             Execute-stage instruction is a load
//  PCSrcE              taken branch/jump resolved in Execute
//  clr_cnt             synchronous clear of both counters
//  StallF, StallD      hold PC / IF-ID
//  FlushD, FlushE      clear IF-ID / ID-EX
//  ForwardAE/BE        EX operand selects (see fwd_sel_e)
//  stall_cnt           load-use stall cycles, saturating
//  flush_cnt           taken-branch cycles, saturating
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RSD1_E,
    input  logic [4:0]       RSD2_E,
    input  logic [4:0]       RdE,
    input  logic             RegWriteE,
    input  logic             IsLoadE,
    input  logic             PCSrcE,
    input  logic             clr_cnt,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    reg_idx_t rd_m_s, rd_w_s;
    logic     regwrite_m_s, regwrite_w_s;

    // A flushed E bubble arrives as RdE=0/RegWriteE=0 and simply becomes a
    // non-writer, so the shadow pipe needs no enable or flush input.
    hazard_shadow_stage u_shadow_mem (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_i       (RdE),
        .regwrite_i (RegWriteE),
        .rd_o       (rd_m_s),
        .regwrite_o (regwrite_m_s)
    );

    hazard_shadow_stage u_shadow_wb (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_i       (rd_m_s),
        .regwrite_i (regwrite_m_s),
        .rd_o       (rd_w_s),
        .regwrite_o (regwrite_w_s)
    );

    logic lw_stall;
    logic stall_evt;

    assign lw_stall  = IsLoadE && (RdE != REG_ZERO) && ((RdE == Rs1D) || (RdE == Rs2D));
    // A taken branch squashes the stalled instruction anyway, so it wins.
    assign stall_evt = lw_stall && !PCSrcE;

    // All controls are held inactive while reset is asserted, independent of inputs.
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        ForwardAE = FWD_NONE;
        ForwardBE = FWD_NONE;
        if (rst_n) begin
            StallF    = stall_evt;
            StallD    = stall_evt;
            FlushD    = PCSrcE;
            FlushE    = lw_stall || PCSrcE;
            ForwardAE = fwd_select(RSD1_E, rd_m_s, regwrite_m_s, rd_w_s, regwrite_w_s);
            ForwardBE = fwd_select(RSD2_E, rd_m_s, regwrite_m_s, rd_w_s, regwrite_w_s);
        end
    end

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (clr_cnt) begin
            stall_cnt_d = CNT_ZERO;
        end else if (stall_evt && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
    end

    always_comb begin
        flush_cnt_d = flush_cnt_q;
        if (clr_cnt) begin
            flush_cnt_d = CNT_ZERO;
        end else if (PCSrcE && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= CNT_ZERO;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt_q <= CNT_ZERO;
        end else begin
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
module tb_hazard_ctrl_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [4:0] Rs1D, Rs2D, RSD1_E, RSD2_E, RdE;
    logic       RegWriteE, IsLoadE, PCSrcE, clr_cnt;

    logic        StallF, StallD, FlushD, FlushE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [15:0] stall_cnt, flush_cnt;

    logic        StallF4, StallD4, FlushD4, FlushE4;
    logic [1:0]  ForwardAE4, ForwardBE4;
    logic [3:0]  stall_cnt4, flush_cnt4;

    hazard_ctrl_unit #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D),
        .RSD1_E(RSD1_E), .RSD2_E(RSD2_E), .RdE(RdE), .RegWriteE(RegWriteE),
        .IsLoadE(IsLoadE), .PCSrcE(PCSrcE), .clr_cnt(clr_cnt),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_ctrl_unit #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D),
        .RSD1_E(RSD1_E), .RSD2_E(RSD2_E), .RdE(RdE), .RegWriteE(RegWriteE),
        .IsLoadE(IsLoadE), .PCSrcE(PCSrcE), .clr_cnt(clr_cnt),
        .StallF(StallF4), .StallD(StallD4), .FlushD(FlushD4), .FlushE(FlushE4),
        .ForwardAE(ForwardAE4), .ForwardBE(ForwardBE4),
        .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );

    int checks = 0;
    int passed = 0;

    // Reference model: list of recent E-stage writers, newest first.
    // Entry 0 has reached MEM, entry 1 has reached WB.
    logic [5:0] hist[$];
    int sc16, fc16, sc4, fc4;

    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        for (int i = 0; i < hist.size() && i < 2; i++) begin
            if (hist[i][5] && hist[i][4:0] != 5'd0 && hist[i][4:0] == rs)
                return (i == 0) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    function automatic logic m_lw();
        return IsLoadE && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);
    endfunction

    function automatic logic [7:0] m_ctrl();
        logic st;
        if (!rst_n) return 8'h00;
        st = m_lw() && !PCSrcE;
        return {st, st, PCSrcE, m_lw() || PCSrcE, m_fwd(RSD1_E), m_fwd(RSD2_E)};
    endfunction

    function automatic int sat_inc(input int v, input int maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    task automatic model_reset();
        hist.delete();
        sc16 = 0; fc16 = 0; sc4 = 0; fc4 = 0;
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (clr_cnt) begin
            sc16 = 0; fc16 = 0; sc4 = 0; fc4 = 0;
        end else begin
            if (m_lw() && !PCSrcE) begin
                sc16 = sat_inc(sc16, 65535);
                sc4  = sat_inc(sc4, 15);
            end
            if (PCSrcE) begin
                fc16 = sat_inc(fc16, 65535);
                fc4  = sat_inc(fc4, 15);
            end
        end
        hist.push_front({RegWriteE, RdE});
        if (hist.size() > 2) void'(hist.pop_back());
    endtask

    task automatic drive(input logic [4:0] rs1d, input logic [4:0] rs2d,
                         input logic [4:0] rs1e, input logic [4:0] rs2e,
                         input logic [4:0] rde, input logic we, input logic ld,
                         input logic pc, input logic clr);
        Rs1D = rs1d; Rs2D = rs2d; RSD1_E = rs1e; RSD2_E = rs2e;
        RdE = rde; RegWriteE = we; IsLoadE = ld; PCSrcE = pc; clr_cnt = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic logic [7:0] obs_ctrl();
        return {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        drive(5'd3, 5'd3, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (obs_ctrl() !== 8'h00) $display("FAIL reset_ctrl: got %b expected %b", obs_ctrl(), 8'h00);
        else passed++;
        tick();
        checks++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || stall_cnt4 !== 4'd0 || flush_cnt4 !== 4'd0)
            $display("FAIL reset_cnt: got %0d/%0d/%0d/%0d expected 0", stall_cnt, flush_cnt, stall_cnt4, flush_cnt4);
        else passed++;
        drive(0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fwd_mem_wb();
        drive(0, 0, 0, 0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(0, 0, 5'd5, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (ForwardAE !== 2'b10 || obs_ctrl() !== m_ctrl())
            $display("FAIL fwd_mem: got %b ctrl %b expected 10 ctrl %b", ForwardAE, obs_ctrl(), m_ctrl());
        else passed++;
        tick();
        @(negedge clk);
        checks++;
        if (ForwardAE !== 2'b01 || obs_ctrl() !== m_ctrl())
            $display("FAIL fwd_wb: got %b ctrl %b expected 01 ctrl %b", ForwardAE, obs_ctrl(), m_ctrl());
        else passed++;
        tick();
        @(negedge clk);
        checks++;
        if (ForwardAE !== 2'b00)
            $display("FAIL fwd_gone: got %b expected 00", ForwardAE);
        else passed++;
        tick();
    endtask

    task automatic test_x0();
        drive(0, 0, 0, 0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(0, 0, 0, 0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (ForwardAE !== 2'b00 || ForwardBE !== 2'b00)
                $display("FAIL x0_fwd%0d: got %b/%b expected 00/00", i, ForwardAE, ForwardBE);
            else passed++;
            tick();
        end
    endtask

    task automatic test_load_use();
        int s0;
        s0 = sc16;
        drive(5'd1, 5'd7, 0, 0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if ({StallF, StallD, FlushD, FlushE} !== 4'b1101 || obs_ctrl() !== m_ctrl())
            $display("FAIL load_use_ctrl: got %b expected %b", obs_ctrl(), m_ctrl());
        else passed++;
        tick();
        checks++;
        if (stall_cnt !== 16'(s0 + 1) || stall_cnt !== 16'(sc16))
            $display("FAIL load_use_cnt: got %0d expected %0d", stall_cnt, s0 + 1);
        else passed++;
        drive(0, 0, 0, 5'd7, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (ForwardBE !== 2'b10 || obs_ctrl() !== m_ctrl())
            $display("FAIL load_fwd_b: got %b expected 10", ForwardBE);
        else passed++;
        tick();
    endtask

    task automatic test_branch_priority();
        int s0, f0;
        s0 = sc16; f0 = fc16;
        drive(5'd3, 0, 0, 0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if ({StallF, StallD, FlushD, FlushE} !== 4'b0011 || obs_ctrl() !== m_ctrl())
            $display("FAIL branch_ctrl: got %b expected %b", obs_ctrl(), m_ctrl());
        else passed++;
        tick();
        checks++;
        if (flush_cnt !== 16'(f0 + 1) || stall_cnt !== 16'(s0))
            $display("FAIL branch_cnt: got %0d/%0d expected %0d/%0d", flush_cnt, stall_cnt, f0 + 1, s0);
        else passed++;
    endtask

    task automatic test_saturation();
        drive(0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checks++;
        if (stall_cnt4 !== 4'd0 || flush_cnt4 !== 4'd0)
            $display("FAIL sat_clear0: got %0d/%0d expected 0/0", stall_cnt4, flush_cnt4);
        else passed++;
        drive(5'd4, 0, 0, 0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (stall_cnt4 !== 4'd15 || stall_cnt4 !== 4'(sc4))
            $display("FAIL sat_stall4: got %0d expected 15", stall_cnt4);
        else passed++;
        checks++;
        if (stall_cnt !== 16'd20 || stall_cnt !== 16'(sc16))
            $display("FAIL sat_stall16: got %0d expected 20", stall_cnt);
        else passed++;
        tick();
        checks++;
        if (stall_cnt4 !== 4'd15)
            $display("FAIL sat_hold: got %0d expected 15", stall_cnt4);
        else passed++;
        clr_cnt = 1'b1;
        tick();
        checks++;
        if (stall_cnt4 !== 4'd0 || stall_cnt !== 16'd0)
            $display("FAIL sat_clr_prio: got %0d/%0d expected 0/0", stall_cnt4, stall_cnt);
        else passed++;
        drive(0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_reset_midstream();
        drive(0, 0, 0, 0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        drive(5'd9, 0, 5'd9, 0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (ForwardAE !== 2'b10 || obs_ctrl() !== m_ctrl())
            $display("FAIL pre_reset_fwd: got %b expected 10", ForwardAE);
        else passed++;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs_ctrl() !== 8'h00 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0)
            $display("FAIL mid_reset: got ctrl %b cnt %0d/%0d expected 0", obs_ctrl(), stall_cnt, flush_cnt);
        else passed++;
        tick();
        drive(0, 0, 5'd9, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (ForwardAE !== 2'b00 || obs_ctrl() !== m_ctrl())
                $display("FAIL post_reset_fwd%0d: got %b expected 00", i, ForwardAE);
            else passed++;
            tick();
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 5) == 0),
                  1'($urandom_range(0, 40) == 0));
            @(negedge clk);
            checks++;
            if (obs_ctrl() !== m_ctrl()) begin
                if (errs < 10) $display("FAIL rand_ctrl[%0d]: got %b expected %b", i, obs_ctrl(), m_ctrl());
                errs++;
            end else passed++;
            tick();
            checks++;
            if (stall_cnt !== 16'(sc16) || flush_cnt !== 16'(fc16) ||
                stall_cnt4 !== 4'(sc4) || flush_cnt4 !== 4'(fc4)) begin
                if (errs < 10)
                    $display("FAIL rand_cnt[%0d]: got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d", i,
                             stall_cnt, flush_cnt, stall_cnt4, flush_cnt4, sc16, fc16, sc4, fc4);
                errs++;
            end else passed++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_fwd_mem_wb();
        test_x0();
        test_load_use();
        test_branch_priority();
        test_saturation();
        test_reset_midstream();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
